// File: rtl/debugger_ps_mailbox_bridge.sv
// PS-side mailbox bridge: writes a request packet into the shared BRAM, pulses the
// debugger, waits for its response interrupt, then streams the length-prefixed
// response back out.
module debugger_ps_mailbox_bridge #(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned REQ_BASE       = 0,
  parameter int unsigned RSP_BASE       = 4096,
  parameter int unsigned REQ_MAX_WORDS  = 64,
  parameter int unsigned RSP_MAX_WORDS  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic                  io_reqValid,
  output logic                  io_reqReady,
  input  logic [31:0]           io_reqData,
  input  logic                  io_reqLast,
  output logic                  io_rspValid,
  input  logic                  io_rspReady,
  output logic [31:0]           io_rspData,
  output logic                  io_rspLast,
  output logic                  io_bramEn,
  output logic                  io_bramWe,
  output logic [ADDR_WIDTH-1:0] io_bramAddr,
  output logic [31:0]           io_bramWrData,
  input  logic [31:0]           io_bramRdData,
  output logic                  io_plInSignal,
  input  logic                  io_psOutInterrupt,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_overflow,
  output logic                  io_timeout
);

  localparam logic [ADDR_WIDTH-1:0] ReqBaseA   = ADDR_WIDTH'(REQ_BASE);
  localparam logic [ADDR_WIDTH-1:0] RspBaseA   = ADDR_WIDTH'(RSP_BASE);
  localparam logic [31:0]           RspMaxW    = RSP_MAX_WORDS;
  localparam logic [31:0]           TimeoutEnd = TIMEOUT_CYCLES - 1;

  typedef enum logic [3:0] {
    StIdle, StWriteReq, StSignal, StWaitIrq, StRdLen,
    StRdLenWait, StRdData, StRdWait, StOutput, StFinish
  } state_e;

  state_e      stateQ, stateD;
  logic [31:0] reqIdxQ, reqIdxD;
  logic [31:0] timeoutCntQ, timeoutCntD;
  logic [31:0] lenQ, lenD;
  logic [31:0] jQ, jD;
  logic [31:0] rspDataQ, rspDataD;
  logic        overflowQ, overflowD;
  logic        timeoutQ, timeoutD;
  logic        irqPrevQ;

  logic        beatFire;
  logic [31:0] beatIdx;
  logic        irqEdge;
  logic [31:0] lenClamped;

  // Only a low-to-high transition counts; a level already high is stale.
  assign irqEdge    = io_psOutInterrupt & ~irqPrevQ;
  assign lenClamped = (io_bramRdData > RspMaxW) ? RspMaxW : io_bramRdData;

  assign io_rspData    = rspDataQ;
  assign io_plInSignal = (stateQ == StSignal);
  assign io_busy       = (stateQ != StIdle);
  assign io_done       = (stateQ == StFinish);
  assign io_overflow   = overflowQ;
  assign io_timeout    = timeoutQ;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ      <= StIdle;
      reqIdxQ     <= '0;
      timeoutCntQ <= '0;
      lenQ        <= '0;
      jQ          <= '0;
      rspDataQ    <= '0;
      overflowQ   <= 1'b0;
      timeoutQ    <= 1'b0;
      irqPrevQ    <= 1'b0;
    end else begin
      stateQ      <= stateD;
      reqIdxQ     <= reqIdxD;
      timeoutCntQ <= timeoutCntD;
      lenQ        <= lenD;
      jQ          <= jD;
      rspDataQ    <= rspDataD;
      overflowQ   <= overflowD;
      timeoutQ    <= timeoutD;
      irqPrevQ    <= io_psOutInterrupt;
    end
  end

  // Next-state logic, BRAM port and stream handshakes.
  always_comb begin
    stateD        = stateQ;
    reqIdxD       = reqIdxQ;
    timeoutCntD   = timeoutCntQ;
    lenD          = lenQ;
    jD            = jQ;
    rspDataD      = rspDataQ;
    overflowD     = overflowQ;
    timeoutD      = timeoutQ;
    io_reqReady   = 1'b0;
    io_rspValid   = 1'b0;
    io_rspLast    = 1'b0;
    io_bramEn     = 1'b0;
    io_bramWe     = 1'b0;
    io_bramAddr   = '0;
    io_bramWrData = '0;
    beatFire      = 1'b0;
    beatIdx       = '0;

    unique case (stateQ)
      StIdle: begin
        // Gate with reset so every output reads 0 while reset is held.
        io_reqReady = io_en & ~reset;
        beatFire    = io_reqValid & io_reqReady;
        if (beatFire) begin
          overflowD = 1'b0;
          timeoutD  = 1'b0;
        end
      end
      StWriteReq: begin
        io_reqReady = 1'b1;
        beatFire    = io_reqValid;
        beatIdx     = reqIdxQ;
      end
      StSignal: begin
        timeoutCntD = '0;
        stateD      = StWaitIrq;
      end
      StWaitIrq: begin
        if (irqEdge) begin
          stateD = StRdLen;
        end else if (timeoutCntQ == TimeoutEnd) begin
          timeoutD = 1'b1;
          stateD   = StFinish;
        end else begin
          timeoutCntD = timeoutCntQ + 32'd1;
        end
      end
      StRdLen: begin
        io_bramEn   = 1'b1;
        io_bramAddr = RspBaseA;
        stateD      = StRdLenWait;
      end
      StRdLenWait: begin
        lenD   = lenClamped;
        jD     = '0;
        stateD = (lenClamped == '0) ? StFinish : StRdData;
      end
      StRdData: begin
        io_bramEn   = 1'b1;
        io_bramAddr = RspBaseA + ADDR_WIDTH'(1) + jQ[ADDR_WIDTH-1:0];
        stateD      = StRdWait;
      end
      StRdWait: begin
        rspDataD = io_bramRdData;
        stateD   = StOutput;
      end
      StOutput: begin
        io_rspValid = 1'b1;
        io_rspLast  = (jQ == lenQ - 32'd1);
        if (io_rspReady) begin
          if (io_rspLast) begin
            stateD = StFinish;
          end else begin
            jD     = jQ + 32'd1;
            stateD = StRdData;
          end
        end
      end
      StFinish: stateD = StIdle;
      default:  stateD = StIdle;
    endcase

    // Shared request-beat handling for IDLE and WRITE_REQ; the index saturates at the cap.
    if (beatFire) begin
      if (beatIdx < REQ_MAX_WORDS) begin
        io_bramEn     = 1'b1;
        io_bramWe     = 1'b1;
        io_bramAddr   = ReqBaseA + beatIdx[ADDR_WIDTH-1:0];
        io_bramWrData = io_reqData;
        reqIdxD       = beatIdx + 32'd1;
      end else begin
        overflowD = 1'b1;
        reqIdxD   = beatIdx;
      end
      stateD = io_reqLast ? StSignal : StWriteReq;
    end
  end

endmodule

// File: tb/tb_debugger_ps_mailbox_bridge.sv
// Directed bench for debugger_ps_mailbox_bridge with a BRAM model and transaction log.
module tb_debugger_ps_mailbox_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_en = 1'b0;
  logic        io_reqValid = 1'b0;
  logic        io_reqReady;
  logic [31:0] io_reqData = '0;
  logic        io_reqLast = 1'b0;
  logic        io_rspValid;
  logic        io_rspReady = 1'b0;
  logic [31:0] io_rspData;
  logic        io_rspLast;
  logic        io_bramEn;
  logic        io_bramWe;
  logic [12:0] io_bramAddr;
  logic [31:0] io_bramWrData;
  logic [31:0] io_bramRdData;
  logic        io_plInSignal;
  logic        io_psOutInterrupt = 1'b0;
  logic        io_busy;
  logic        io_done;
  logic        io_overflow;
  logic        io_timeout;

  int testCount = 0;
  int failCount = 0;

  debugger_ps_mailbox_bridge #(
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock), .reset(reset), .io_en(io_en),
    .io_reqValid(io_reqValid), .io_reqReady(io_reqReady), .io_reqData(io_reqData),
    .io_reqLast(io_reqLast), .io_rspValid(io_rspValid), .io_rspReady(io_rspReady),
    .io_rspData(io_rspData), .io_rspLast(io_rspLast), .io_bramEn(io_bramEn),
    .io_bramWe(io_bramWe), .io_bramAddr(io_bramAddr), .io_bramWrData(io_bramWrData),
    .io_bramRdData(io_bramRdData), .io_plInSignal(io_plInSignal),
    .io_psOutInterrupt(io_psOutInterrupt), .io_busy(io_busy), .io_done(io_done),
    .io_overflow(io_overflow), .io_timeout(io_timeout)
  );

  always #5 clock = ~clock;

  // BRAM model with a backdoor poke port for preloading the response area.
  logic [31:0] mem [0:8191];
  logic        pokeEn = 1'b0;
  logic [12:0] pokeAddr = '0;
  logic [31:0] pokeData = '0;
  always @(posedge clock) begin
    if (pokeEn) mem[pokeAddr] <= pokeData;
    else if (io_bramEn && io_bramWe) mem[io_bramAddr] <= io_bramWrData;
    if (io_bramEn && !io_bramWe) io_bramRdData <= mem[io_bramAddr];
  end

  // Transaction log.
  logic        logClr = 1'b0;
  int          wrCnt, plCnt, doneCnt, rspCnt, reqAccCnt;
  logic [12:0] wrAddrLog [0:127];
  logic [31:0] wrDataLog [0:127];
  logic [31:0] rspDataLog [0:127];
  logic        rspLastLog [0:127];
  always @(posedge clock) begin
    if (logClr) begin
      wrCnt <= 0; plCnt <= 0; doneCnt <= 0; rspCnt <= 0; reqAccCnt <= 0;
    end else begin
      if (io_bramEn && io_bramWe) begin
        wrAddrLog[wrCnt[6:0]] <= io_bramAddr;
        wrDataLog[wrCnt[6:0]] <= io_bramWrData;
        wrCnt <= wrCnt + 1;
      end
      if (io_rspValid && io_rspReady) begin
        rspDataLog[rspCnt[6:0]] <= io_rspData;
        rspLastLog[rspCnt[6:0]] <= io_rspLast;
        rspCnt <= rspCnt + 1;
      end
      if (io_plInSignal) plCnt <= plCnt + 1;
      if (io_done) doneCnt <= doneCnt + 1;
      if (io_reqValid && io_reqReady) reqAccCnt <= reqAccCnt + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clearLog();
    logClr = 1'b1;
    @(negedge clock);
    logClr = 1'b0;
  endtask

  task automatic bramPoke(input logic [12:0] addr, input logic [31:0] data);
    pokeEn = 1'b1; pokeAddr = addr; pokeData = data;
    @(negedge clock);
    pokeEn = 1'b0;
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      0:       return io_plInSignal;
      1:       return io_done;
      default: return io_rspValid;
    endcase
  endfunction

  // Bounded wait on a DUT output; an expired bound is reported as a failed comparison.
  task automatic waitSig(input int which, input int maxCyc, input string tag);
    int n = 0;
    while (!sigSel(which) && n < maxCyc) begin
      @(negedge clock);
      n++;
    end
    checkVal(tag, {31'd0, sigSel(which)}, 32'd1);
  endtask

  task automatic sendReq(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      io_reqValid = 1'b1;
      io_reqData  = base + 32'(i);
      io_reqLast  = (i == n - 1);
      @(negedge clock);
    end
    io_reqValid = 1'b0;
    io_reqLast  = 1'b0;
  endtask

  task automatic pulseIrq();
    io_psOutInterrupt = 1'b1;
    @(negedge clock);
    io_psOutInterrupt = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    #100;
    @(negedge clock);
    reset = 1'b0;
    checkVal("rst_busy", {31'd0, io_busy}, 32'd0);
    checkVal("rst_reqReady", {31'd0, io_reqReady}, 32'd0);
    checkVal("rst_rspValid", {31'd0, io_rspValid}, 32'd0);
    checkVal("rst_flags", {29'd0, io_done, io_overflow, io_timeout}, 32'd0);
    checkVal("rst_bramEn", {31'd0, io_bramEn}, 32'd0);

    // Basic transaction.
    bramPoke(13'd4096, 32'd2);
    bramPoke(13'd4097, 32'hB0);
    bramPoke(13'd4098, 32'hB1);
    io_en = 1'b1;
    io_rspReady = 1'b1;
    clearLog();
    sendReq(3, 32'hA0);
    waitSig(0, 10, "basic_plin");
    waitCycles(5);
    pulseIrq();
    waitSig(1, 50, "basic_done");
    waitCycles(1);
    checkVal("basic_wrCnt", wrCnt, 3);
    for (int i = 0; i < 3; i++) begin
      checkVal("basic_wrAddr", {19'd0, wrAddrLog[i]}, i);
      checkVal("basic_wrData", wrDataLog[i], 32'hA0 + 32'(i));
    end
    checkVal("basic_plCnt", plCnt, 1);
    checkVal("basic_rspCnt", rspCnt, 2);
    checkVal("basic_rsp0", rspDataLog[0], 32'hB0);
    checkVal("basic_last0", {31'd0, rspLastLog[0]}, 32'd0);
    checkVal("basic_rsp1", rspDataLog[1], 32'hB1);
    checkVal("basic_last1", {31'd0, rspLastLog[1]}, 32'd1);
    checkVal("basic_doneCnt", doneCnt, 1);
    checkVal("basic_busy", {31'd0, io_busy}, 32'd0);

    // Overflow with a zero-length response.
    bramPoke(13'd4096, 32'd0);
    clearLog();
    sendReq(70, 32'h100);
    checkVal("ovf_flag", {31'd0, io_overflow}, 32'd1);
    waitSig(0, 5, "ovf_plin");
    waitCycles(2);
    pulseIrq();
    waitSig(1, 20, "ovf_done");
    waitCycles(1);
    checkVal("ovf_wrCnt", wrCnt, 64);
    checkVal("ovf_wrAddr0", {19'd0, wrAddrLog[0]}, 32'd0);
    checkVal("ovf_wrAddr63", {19'd0, wrAddrLog[63]}, 32'd63);
    checkVal("ovf_wrData63", wrDataLog[63], 32'h13F);
    checkVal("ovf_reqAcc", reqAccCnt, 70);
    checkVal("zero_rspCnt", rspCnt, 0);
    checkVal("zero_doneCnt", doneCnt, 1);
    checkVal("ovf_sticky", {31'd0, io_overflow}, 32'd1);

    // Timeout: done and flag land exactly 20 cycles after WAIT_IRQ entry.
    clearLog();
    sendReq(1, 32'h55);
    checkVal("to_ovfClr", {31'd0, io_overflow}, 32'd0);
    waitSig(0, 5, "to_plin");
    waitCycles(20);
    checkVal("to_early_done", {31'd0, io_done}, 32'd0);
    checkVal("to_early_flag", {31'd0, io_timeout}, 32'd0);
    waitCycles(1);
    checkVal("to_done", {31'd0, io_done}, 32'd1);
    checkVal("to_flag", {31'd0, io_timeout}, 32'd1);
    waitCycles(1);
    checkVal("to_rspCnt", rspCnt, 0);
    checkVal("to_busy", {31'd0, io_busy}, 32'd0);

    // Length clamp: 100 requested, 64 delivered.
    bramPoke(13'd4096, 32'd100);
    for (int j = 0; j < 65; j++) bramPoke(13'd4097 + 13'(j), 32'hC000 + 32'(j));
    clearLog();
    sendReq(2, 32'h1);
    checkVal("clamp_toClr", {31'd0, io_timeout}, 32'd0);
    waitSig(0, 5, "clamp_plin");
    waitCycles(3);
    pulseIrq();
    waitSig(1, 400, "clamp_done");
    waitCycles(1);
    checkVal("clamp_rspCnt", rspCnt, 64);
    checkVal("clamp_rsp0", rspDataLog[0], 32'hC000);
    checkVal("clamp_rsp63", rspDataLog[63], 32'hC03F);
    checkVal("clamp_last62", {31'd0, rspLastLog[62]}, 32'd0);
    checkVal("clamp_last63", {31'd0, rspLastLog[63]}, 32'd1);

    // Stale interrupt level and backpressure.
    bramPoke(13'd4096, 32'd1);
    bramPoke(13'd4097, 32'hDEADBEEF);
    clearLog();
    io_rspReady = 1'b0;
    io_psOutInterrupt = 1'b1;
    sendReq(1, 32'h7);
    waitSig(0, 5, "stale_plin");
    waitCycles(8);
    checkVal("stale_busy", {31'd0, io_busy}, 32'd1);
    checkVal("stale_noRsp", {31'd0, io_rspValid}, 32'd0);
    io_psOutInterrupt = 1'b0;
    waitCycles(1);
    io_psOutInterrupt = 1'b1;
    waitSig(2, 10, "bp_valid");
    held = io_rspData;
    checkVal("bp_data", held, 32'hDEADBEEF);
    for (int k = 0; k < 10; k++) begin
      waitCycles(1);
      checkVal("bp_validHeld", {31'd0, io_rspValid}, 32'd1);
      checkVal("bp_dataHeld", io_rspData, held);
    end
    checkVal("bp_last", {31'd0, io_rspLast}, 32'd1);
    checkVal("bp_rspCnt0", rspCnt, 0);
    io_rspReady = 1'b1;
    waitSig(1, 5, "bp_done");
    waitCycles(1);
    checkVal("bp_rspCnt", rspCnt, 1);
    io_psOutInterrupt = 1'b0;

    // Reset in WAIT_IRQ with sticky overflow set.
    sendReq(66, 32'h200);
    waitSig(0, 5, "mid_plin");
    waitCycles(3);
    checkVal("mid_ovf", {31'd0, io_overflow}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("mid_busy", {31'd0, io_busy}, 32'd0);
    checkVal("mid_reqReady", {31'd0, io_reqReady}, 32'd0);
    checkVal("mid_bram", {30'd0, io_bramEn, io_bramWe}, 32'd0);
    checkVal("mid_pulses", {30'd0, io_plInSignal, io_done}, 32'd0);
    checkVal("mid_rsp", {30'd0, io_rspValid, io_rspLast}, 32'd0);
    checkVal("mid_flags", {30'd0, io_overflow, io_timeout}, 32'd0);
    waitCycles(2);
    reset = 1'b0;

    // io_en gating in IDLE.
    clearLog();
    io_en = 1'b0;
    io_reqValid = 1'b1;
    io_reqData = 32'h99;
    io_reqLast = 1'b1;
    waitCycles(1);
    checkVal("en_reqReady", {31'd0, io_reqReady}, 32'd0);
    waitCycles(4);
    checkVal("en_busy", {31'd0, io_busy}, 32'd0);
    checkVal("en_reqAcc", reqAccCnt, 0);
    checkVal("en_wrCnt", wrCnt, 0);
    io_reqValid = 1'b0;
    io_reqLast = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/debugger_ps_mailbox_bridge.md
Name: debugger_ps_mailbox_bridge

Overview:
- PS-side bridge that drives the debugger core's shared-BRAM mailbox and its handshake lines.
- Accepts a request packet on a valid/ready stream and writes it into the request area of the BRAM.
- Signals the debugger on io_plInSignal, waits for a rising edge on io_psOutInterrupt, then reads the length-prefixed response area back out on a valid/ready stream.
- Sits directly upstream of the debugger's io_plInSignal input and directly downstream of its io_psOutInterrupt output.

Parameters:
- ADDR_WIDTH, 13, BRAM word-address width.
- REQ_BASE, 0, word address of the first request word.
- RSP_BASE, 4096, word address of the response length word; response data starts at RSP_BASE+1.
- REQ_MAX_WORDS, 64, maximum number of request words written; further beats are discarded.
- RSP_MAX_WORDS, 64, clamp applied to the response length.
- TIMEOUT_CYCLES, 100000, number of WAIT_IRQ cycles before abort (32-bit counter).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- io_en  in  1  permits a new transaction to start from IDLE.
- io_reqValid  in  1  request beat valid.
- io_reqReady  out  1  request beat accepted this cycle.
- io_reqData  in  32  request word.
- io_reqLast  in  1  final request beat.
- io_rspValid  out  1  response beat valid.
- io_rspReady  in  1  response consumer ready.
- io_rspData  out  32  response word.
- io_rspLast  out  1  final response beat.
- io_bramEn  out  1  BRAM port enable.
- io_bramWe  out  1  BRAM write enable.
- io_bramAddr  out  ADDR_WIDTH  BRAM word address.
- io_bramWrData  out  32  BRAM write data.
- io_bramRdData  in  32  BRAM read data, valid 1 cycle after io_bramEn with io_bramWe=0.
- io_plInSignal  out  1  1-cycle pulse to the debugger: request ready.
- io_psOutInterrupt  in  1  debugger response-ready interrupt, level signal.
- io_busy  out  1  high in any state other than IDLE.
- io_done  out  1  1-cycle pulse at the end of every transaction.
- io_overflow  out  1  sticky: request exceeded REQ_MAX_WORDS.
- io_timeout  out  1  sticky: no interrupt within TIMEOUT_CYCLES.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE and all outputs go to 0.
  - Word counters, timeout counter, interrupt-edge register and sticky flags clear.
  - BRAM contents are not touched.
- States: IDLE, WRITE_REQ, SIGNAL, WAIT_IRQ, RD_LEN, RD_LEN_WAIT, RD_DATA, RD_WAIT, OUTPUT, FINISH.
- IDLE:
  - io_reqReady = io_en.
  - A first accepted beat clears io_overflow and io_timeout and is handled exactly as a WRITE_REQ beat (word index 0).
  - Next state is WRITE_REQ, or SIGNAL if that beat has io_reqLast=1.
- WRITE_REQ:
  - io_reqReady=1.
  - Each accepted beat with index i < REQ_MAX_WORDS drives, in the same cycle and combinationally from the handshake: io_bramEn=1, io_bramWe=1, io_bramAddr=REQ_BASE+i, io_bramWrData=io_reqData.
  - Beats with i >= REQ_MAX_WORDS are accepted but not written (io_bramWe=0), and set io_overflow.
  - An accepted beat with io_reqLast=1 moves to SIGNAL.
  - io_en is ignored once the transaction has started.
- SIGNAL: io_plInSignal=1 for exactly one cycle; the timeout counter is cleared; next state is WAIT_IRQ.
- WAIT_IRQ:
  - Rising-edge detect on io_psOutInterrupt, using a registered copy of the previous value. Edges in any other state are ignored; a level that is already high on entry is not an edge.
  - An edge moves to RD_LEN.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 without an edge: set io_timeout and go to FINISH.
  - If an edge and the timeout fall in the same cycle, the edge wins.
- Length read:
  - RD_LEN issues a read at RSP_BASE.
  - RD_LEN_WAIT captures len = min(io_bramRdData, RSP_MAX_WORDS).
  - len==0 goes to FINISH with no response beats; otherwise go to RD_DATA with j=0.
- Data read and output:
  - RD_DATA issues a read at RSP_BASE+1+j.
  - RD_WAIT registers the data into io_rspData.
  - OUTPUT holds io_rspValid=1, io_rspData stable, and io_rspLast=(j==len-1) until io_rspReady.
  - On handshake: if last go to FINISH, else j++ and go to RD_DATA.
  - Throughput is at most one beat per 3 cycles.
  - io_rspValid stays asserted without the handshake when io_rspReady is low, indefinitely (no timeout in OUTPUT).
- FINISH: io_done=1 for one cycle; next state is IDLE.
- Status: io_busy=1 in every non-IDLE state.
- Arithmetic: all BRAM addresses wrap modulo 2^ADDR_WIDTH.

Test Plan:
- Basic transaction:
  - Stimulus: reset held 100 ns, then release. Send 3 beats 0xA0,0xA1,0xA2 (last on 3rd). Pulse the interrupt 5 cycles after io_plInSignal. BRAM[4096]=2, [4097]=0xB0, [4098]=0xB1.
  - Required: writes at addresses 0,1,2; exactly one io_plInSignal pulse; rsp beats 0xB0, then 0xB1 with io_rspLast; one io_done.
- Overflow:
  - Stimulus: 70-beat request.
  - Required: 64 BRAM writes at addresses 0..63; all 70 beats accepted; io_overflow=1 until the next request.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20, no interrupt.
  - Required: io_timeout=1 and io_done pulse exactly 20 cycles after WAIT_IRQ entry; no response beats.
- Zero length and length clamp:
  - Stimulus A: BRAM[4096]=0. Required: io_done, no beats.
  - Stimulus B: BRAM[4096]=100. Required: exactly 64 beats, io_rspLast on the 64th.
- Backpressure and stale interrupt:
  - Stimulus: io_rspReady low for 10 cycles; io_psOutInterrupt held high before WAIT_IRQ.
  - Required: data stable while valid is held; the bridge waits for a fresh rising edge.
- Reset mid-operation and io_en gating:
  - Stimulus: assert reset in WAIT_IRQ; separately, hold io_en=0 in IDLE.
  - Required: on reset, all outputs 0 asynchronously and state IDLE. With io_en=0, io_reqReady=0 and no transaction starts.
